// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared widths, zero-register id and write-request type
// Used by the writeback queue, the register file and both write producers.
package writeback_queue_pkg;

  localparam int WB_DATA_WIDTH = 16;
  localparam int WB_ADDR_WIDTH = 3;
  localparam logic [2:0] ZERO_REG = 3'd0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] value;
  } wb_req_t;

endpackage

// File: rtl/writeback_queue_hazard_match.sv
// rtl/writeback_queue_hazard_match.sv - one read address against all live queue entries
// Reads of the hardwired zero register never report a hazard.
module wb_hazard_match
  import writeback_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
  input  logic [DEPTH-1:0]                 entry_valid,
  output logic                             hit
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = entry_valid[i] && (entry_addr[i] == read_addr);
    end
    hit = (read_addr != ADDR_WIDTH'(ZERO_REG)) && (|match);
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - mem/ALU writeback buffer draining into the register file write port
// Mem request is stored ahead of a same-cycle ALU request; zero-register writes are dropped.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0]   mem_wb_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wb_value,
  output logic                    mem_wb_ready,
  input  logic                    alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0]   alu_wb_addr,
  input  logic [DATA_WIDTH-1:0]   alu_wb_value,
  output logic                    alu_wb_ready,
  input  logic                    drain_hold,
  input  logic [ADDR_WIDTH-1:0]   read_a_addr,
  input  logic [ADDR_WIDTH-1:0]   read_b_addr,
  output logic                    hazard_a,
  output logic                    hazard_b,
  output logic                    reg_write,
  output logic [ADDR_WIDTH-1:0]   reg_write_address,
  output logic [DATA_WIDTH-1:0]   reg_write_value,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0]                  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] value_q, value_d;
  logic [DEPTH-1:0]               valid_mask;
  logic                           full, empty, mem_store, alu_store, pop;
  logic [PW-1:0]                  alu_slot;

  always_comb begin
    full  = (count_q == DEPTH_C);
    empty = (count_q == '0);
    // Ready uses the registered count only, so a pop never makes room in the same cycle.
    mem_wb_ready = !full;
    alu_wb_ready = (count_q <= DEPTH_C - CW'(2)) ||
                   ((count_q == DEPTH_C - CW'(1)) && !mem_wb_valid);
    mem_store = mem_wb_valid && mem_wb_ready && (mem_wb_addr != ZERO_ADDR);
    alu_store = alu_wb_valid && alu_wb_ready && (alu_wb_addr != ZERO_ADDR);
    pop       = !empty && !drain_hold;

    alu_slot = tail_q + PW'(mem_store);
    addr_d   = addr_q;
    value_d  = value_q;
    if (mem_store) begin
      addr_d[tail_q]  = mem_wb_addr;
      value_d[tail_q] = mem_wb_value;
    end
    if (alu_store) begin
      addr_d[alu_slot]  = alu_wb_addr;
      value_d[alu_slot] = alu_wb_value;
    end
    tail_d  = alu_slot + PW'(alu_store);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(mem_store) + CW'(alu_store) - CW'(pop);
  end

  // An entry is live when its distance from head is below the stored count.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  assign reg_write         = !empty;
  assign reg_write_address = addr_q[head_q];
  assign reg_write_value   = value_q[head_q];
  assign occupancy         = count_q;

  wb_hazard_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_hazard_a (
    .read_addr   (read_a_addr),
    .entry_addr  (addr_q),
    .entry_valid (valid_mask),
    .hit         (hazard_a)
  );

  wb_hazard_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_hazard_b (
    .read_addr   (read_b_addr),
    .entry_addr  (addr_q),
    .entry_valid (valid_mask),
    .hit         (hazard_b)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          mem_wb_valid, alu_wb_valid, drain_hold;
  logic [AW-1:0] mem_wb_addr, alu_wb_addr, read_a_addr, read_b_addr;
  logic [DW-1:0] mem_wb_value, alu_wb_value;
  logic          mem_wb_ready, alu_wb_ready, hazard_a, hazard_b, reg_write;
  logic [AW-1:0] reg_write_address;
  logic [DW-1:0] reg_write_value;
  logic [2:0]    occupancy;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] value;
  } ent_t;

  ent_t          sb[$];
  logic [DW-1:0] rf [0:7];
  int            checks = 0;
  int            failures = 0;
  int            mon_n;
  logic          exp_mr, exp_ar, exp_ha, exp_hb;

  writeback_queue dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_addr       (mem_wb_addr),
    .mem_wb_value      (mem_wb_value),
    .mem_wb_ready      (mem_wb_ready),
    .alu_wb_valid      (alu_wb_valid),
    .alu_wb_addr       (alu_wb_addr),
    .alu_wb_value      (alu_wb_value),
    .alu_wb_ready      (alu_wb_ready),
    .drain_hold        (drain_hold),
    .read_a_addr       (read_a_addr),
    .read_b_addr       (read_b_addr),
    .hazard_a          (hazard_a),
    .hazard_b          (hazard_b),
    .reg_write         (reg_write),
    .reg_write_address (reg_write_address),
    .reg_write_value   (reg_write_value),
    .occupancy         (occupancy)
  );

  always #5 CLK = ~CLK;

  // Reference model: expected entries queued on acceptance, compared and retired as they drain.
  always @(negedge CLK) begin
    if (RST_N) begin
      mon_n  = sb.size();
      exp_mr = (mon_n < DEPTH);
      exp_ar = (mon_n <= DEPTH - 2) || ((mon_n == DEPTH - 1) && !mem_wb_valid);
      exp_ha = 1'b0;
      exp_hb = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].addr == read_a_addr) exp_ha = 1'b1;
        if (sb[i].addr == read_b_addr) exp_hb = 1'b1;
      end
      if (read_a_addr == 0) exp_ha = 1'b0;
      if (read_b_addr == 0) exp_hb = 1'b0;

      checks++;
      if (occupancy !== 3'(mon_n)) begin
        failures++;
        $display("FAIL mon_occupancy got=%0d exp=%0d", occupancy, mon_n);
      end
      checks++;
      if (mem_wb_ready !== exp_mr) begin
        failures++;
        $display("FAIL mon_mem_ready got=%b exp=%b", mem_wb_ready, exp_mr);
      end
      checks++;
      if (alu_wb_ready !== exp_ar) begin
        failures++;
        $display("FAIL mon_alu_ready got=%b exp=%b", alu_wb_ready, exp_ar);
      end
      checks++;
      if (hazard_a !== exp_ha || hazard_b !== exp_hb) begin
        failures++;
        $display("FAIL mon_hazard got=%b%b exp=%b%b", hazard_a, hazard_b, exp_ha, exp_hb);
      end
      checks++;
      if (reg_write !== (mon_n != 0)) begin
        failures++;
        $display("FAIL mon_reg_write got=%b exp=%b", reg_write, (mon_n != 0));
      end
      if (reg_write === 1'b1) rf[reg_write_address] = reg_write_value;
      if (mon_n != 0) begin
        checks++;
        if (reg_write_address !== sb[0].addr || reg_write_value !== sb[0].value) begin
          failures++;
          $display("FAIL mon_head got=%0d:%h exp=%0d:%h", reg_write_address, reg_write_value,
                   sb[0].addr, sb[0].value);
        end
        if (!drain_hold) sb.delete(0);
      end
      if (mem_wb_valid && exp_mr && mem_wb_addr != 0) sb.push_back({mem_wb_addr, mem_wb_value});
      if (alu_wb_valid && exp_ar && alu_wb_addr != 0) sb.push_back({alu_wb_addr, alu_wb_value});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 12 && occupancy != 0; k++) step();
    checks++;
    if (occupancy !== 3'd0) begin
      failures++;
      $display("FAIL %s_drain_timeout got=%0d exp=0", name, occupancy);
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    mem_wb_valid = 0; alu_wb_valid = 0; drain_hold = 0;
    mem_wb_addr = 0; alu_wb_addr = 0; mem_wb_value = 0; alu_wb_value = 0;
    read_a_addr = 0; read_b_addr = 0;
    sb.delete();
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    read_a_addr = 3'd1;
    read_b_addr = 3'd5;
    @(negedge CLK);
    checks++;
    if (reg_write !== 1'b0 || occupancy !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%b/%0d exp=0/0", reg_write, occupancy);
    end
    checks++;
    if (hazard_a !== 1'b0 || hazard_b !== 1'b0 || reg_write_address !== 3'd0 || reg_write_value !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b %0d %h exp=00 0 0000", hazard_a, hazard_b,
               reg_write_address, reg_write_value);
    end
    step();
    read_a_addr = 0;
    read_b_addr = 0;
  endtask

  task automatic test_single_alu();
    alu_wb_valid = 1; alu_wb_addr = 3'd3; alu_wb_value = 16'h00AB;
    step();
    alu_wb_valid = 0;
    @(negedge CLK);
    checks++;
    if (reg_write !== 1'b1 || reg_write_address !== 3'd3 || reg_write_value !== 16'h00AB) begin
      failures++;
      $display("FAIL single_alu_out got=%b %0d %h exp=1 3 00ab", reg_write, reg_write_address, reg_write_value);
    end
    step();
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd0 || rf[3] !== 16'h00AB) begin
      failures++;
      $display("FAIL single_alu_rf got=%0d %h exp=0 00ab", occupancy, rf[3]);
    end
    step();
  endtask

  task automatic test_same_cycle();
    read_a_addr = 3'd2;
    mem_wb_valid = 1; mem_wb_addr = 3'd2; mem_wb_value = 16'h1111;
    alu_wb_valid = 1; alu_wb_addr = 3'd2; alu_wb_value = 16'h2222;
    step();
    mem_wb_valid = 0; alu_wb_valid = 0;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd2 || hazard_a !== 1'b1 || reg_write_value !== 16'h1111) begin
      failures++;
      $display("FAIL same_cycle_first got=%0d %b %h exp=2 1 1111", occupancy, hazard_a, reg_write_value);
    end
    step();
    @(negedge CLK);
    checks++;
    if (hazard_a !== 1'b1 || reg_write_value !== 16'h2222) begin
      failures++;
      $display("FAIL same_cycle_second got=%b %h exp=1 2222", hazard_a, reg_write_value);
    end
    step();
    @(negedge CLK);
    checks++;
    if (hazard_a !== 1'b0 || occupancy !== 3'd0 || rf[2] !== 16'h2222) begin
      failures++;
      $display("FAIL same_cycle_final got=%b %0d %h exp=0 0 2222", hazard_a, occupancy, rf[2]);
    end
    step();
    read_a_addr = 0;
  endtask

  task automatic test_hold_fill();
    drain_hold = 1;
    for (int i = 0; i < 4; i++) begin
      mem_wb_valid = 1; mem_wb_addr = 3'(4 + i); mem_wb_value = 16'hA000 + 16'(i);
      step();
    end
    mem_wb_valid = 0;
    alu_wb_valid = 1; alu_wb_addr = 3'd1; alu_wb_value = 16'h0BAD;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd4 || mem_wb_ready !== 1'b0 || alu_wb_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_full got=%0d %b %b exp=4 0 0", occupancy, mem_wb_ready, alu_wb_ready);
    end
    step();
    alu_wb_valid = 0;
    drain_hold = 0;
    wait_drain("hold_fill");
    checks++;
    if (rf[4] !== 16'hA000 || rf[7] !== 16'hA003 || rf[1] === 16'h0BAD) begin
      failures++;
      $display("FAIL hold_fill_rf got=%h %h %h exp=a000 a003 !0bad", rf[4], rf[7], rf[1]);
    end
  endtask

  task automatic test_contention();
    drain_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_wb_valid = 1; alu_wb_addr = 3'(1 + i); alu_wb_value = 16'hC000 + 16'(i);
      step();
    end
    drain_hold = 0;
    mem_wb_valid = 1; mem_wb_addr = 3'd5; mem_wb_value = 16'h5555;
    alu_wb_valid = 1; alu_wb_addr = 3'd6; alu_wb_value = 16'h6666;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd3 || mem_wb_ready !== 1'b1 || alu_wb_ready !== 1'b0) begin
      failures++;
      $display("FAIL contention_stall got=%0d %b %b exp=3 1 0", occupancy, mem_wb_ready, alu_wb_ready);
    end
    step();
    mem_wb_valid = 0;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd3 || alu_wb_ready !== 1'b1) begin
      failures++;
      $display("FAIL contention_accept got=%0d %b exp=3 1", occupancy, alu_wb_ready);
    end
    step();
    alu_wb_valid = 0;
    wait_drain("contention");
    checks++;
    if (rf[5] !== 16'h5555 || rf[6] !== 16'h6666 || rf[3] !== 16'hC002) begin
      failures++;
      $display("FAIL contention_rf got=%h %h %h exp=5555 6666 c002", rf[5], rf[6], rf[3]);
    end
  endtask

  task automatic test_zero_addr();
    read_a_addr = 0; read_b_addr = 0;
    mem_wb_valid = 1; mem_wb_addr = 0; mem_wb_value = 16'hFFFF;
    alu_wb_valid = 1; alu_wb_addr = 0; alu_wb_value = 16'hFFFF;
    @(negedge CLK);
    checks++;
    if (mem_wb_ready !== 1'b1 || alu_wb_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready got=%b %b exp=1 1", mem_wb_ready, alu_wb_ready);
    end
    step();
    mem_wb_valid = 0; alu_wb_valid = 0;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd0 || reg_write !== 1'b0 || hazard_a !== 1'b0 || rf[0] !== 16'h0) begin
      failures++;
      $display("FAIL zero_dropped got=%0d %b %b %h exp=0 0 0 0000", occupancy, reg_write, hazard_a, rf[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drain_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_wb_valid = 1; alu_wb_addr = 3'(1 + i); alu_wb_value = 16'hD001 + 16'(i);
      step();
    end
    alu_wb_valid = 0;
    read_a_addr = 3'd2;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd3 || hazard_a !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got=%0d %b exp=3 1", occupancy, hazard_a);
    end
    #2;
    RST_N = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (reg_write !== 1'b0 || occupancy !== 3'd0 || hazard_a !== 1'b0 ||
        reg_write_address !== 3'd0 || reg_write_value !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b %0d %b %0d %h exp=0 0 0 0 0000", reg_write, occupancy,
               hazard_a, reg_write_address, reg_write_value);
    end
    step();
    drain_hold = 0;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (occupancy !== 3'd0 || reg_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after got=%0d %b exp=0 0", occupancy, reg_write);
    end
    step();
    read_a_addr = 0;
  endtask

  initial begin
    for (int r = 0; r < 8; r++) rf[r] = '0;
    do_reset();
    test_reset();
    test_single_alu();
    test_same_cycle();
    test_hold_fill();
    test_contention();
    test_zero_addr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
